// File: rtl/prefix_subtractor_32bit_pipe_pkg.sv
// Shared constants and types for the pipelined prefix subtractor.
//   WIDTH        : operand width (SLICE * NSLICE)
//   SLICE        : bits per Kogge-Stone slice
//   NSLICE       : number of slices, derived from WIDTH / SLICE
//   SLICE_LEVELS : prefix levels inside one slice
//   s1_entry_t   : everything stage 1 hands to stage 2
package prefix_sub_pkg;

  localparam int WIDTH        = 32;
  localparam int SLICE        = 8;
  localparam int NSLICE       = WIDTH / SLICE;
  localparam int SLICE_LEVELS = $clog2(SLICE);

  typedef logic [SLICE-1:0] slice_t;

  // Both carry-in candidates of every slice travel together with the
  // slice group generate/propagate, so stage 2 only has to pick one sum.
  typedef struct packed {
    slice_t [NSLICE-1:0] sum0;
    slice_t [NSLICE-1:0] sum1;
    logic   [NSLICE-1:0] g;
    logic   [NSLICE-1:0] p;
    logic                a_msb;
    logic                b_msb;
  } s1_entry_t;

endpackage

// File: rtl/prefix_subtractor_32bit_pipe_if.sv
// Stream bundle of the subtractor.
//   in_valid/in_ready   : operand handshake, a = minuend, b = subtrahend
//   out_valid/out_ready : result handshake
//   diff, borrow, ovf, zero : result and status flags
// master = producer/consumer side, slave = the subtractor.
interface prefix_subtractor_32bit_pipe_if;

  logic                             in_valid;
  logic                             in_ready;
  logic [prefix_sub_pkg::WIDTH-1:0] a;
  logic [prefix_sub_pkg::WIDTH-1:0] b;
  logic                             out_valid;
  logic                             out_ready;
  logic [prefix_sub_pkg::WIDTH-1:0] diff;
  logic                             borrow;
  logic                             ovf;
  logic                             zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf, zero
  );

endinterface

// File: rtl/prefix_subtractor_32bit_pipe_slice.sv
// prefix_slice_8bit_cs: combinational Kogge-Stone slice with carry-select.
//   a     : minuend slice
//   bp    : inverted subtrahend slice
//   sum0  : slice sum assuming carry-in 0
//   sum1  : slice sum assuming carry-in 1
//   g_grp : slice group generate
//   p_grp : slice group propagate
module prefix_slice_8bit_cs
  import prefix_sub_pkg::*;
(
  input  slice_t a,
  input  slice_t bp,
  output slice_t sum0,
  output slice_t sum1,
  output logic   g_grp,
  output logic   p_grp
);

  // Level L bit i holds the group (G,P) over bits [i : max(0, i-2^L+1)];
  // after the last level every bit covers down to bit 0.
  logic [SLICE_LEVELS:0][SLICE-1:0] g_lvl;
  logic [SLICE_LEVELS:0][SLICE-1:0] p_lvl;

  assign g_lvl[0] = a & bp;
  assign p_lvl[0] = a ^ bp;

  generate
    for (genvar li = 0; li < SLICE_LEVELS; li++) begin : g_level
      localparam int DIST = 1 << li;
      for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
        if (gi >= DIST) begin : g_comb
          assign g_lvl[li+1][gi] = g_lvl[li][gi] | (p_lvl[li][gi] & g_lvl[li][gi-DIST]);
          assign p_lvl[li+1][gi] = p_lvl[li][gi] & p_lvl[li][gi-DIST];
        end else begin : g_pass
          assign g_lvl[li+1][gi] = g_lvl[li][gi];
          assign p_lvl[li+1][gi] = p_lvl[li][gi];
        end
      end
    end
  endgenerate

  // Carry into bit i is G[i-1] for carry-in 0 and G[i-1] | P[i-1] for 1.
  assign sum0[0] = p_lvl[0][0];
  assign sum1[0] = ~p_lvl[0][0];

  generate
    for (genvar gi = 1; gi < SLICE; gi++) begin : g_sum
      assign sum0[gi] = p_lvl[0][gi] ^ g_lvl[SLICE_LEVELS][gi-1];
      assign sum1[gi] = p_lvl[0][gi] ^ (g_lvl[SLICE_LEVELS][gi-1] | p_lvl[SLICE_LEVELS][gi-1]);
    end
  endgenerate

  assign g_grp = g_lvl[SLICE_LEVELS][SLICE-1];
  assign p_grp = p_lvl[SLICE_LEVELS][SLICE-1];

endmodule

// File: rtl/prefix_subtractor_32bit_pipe.sv
// Two-stage pipelined subtractor, diff = a + ~b + 1.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of the stream bundle (operands in, result + flags out)
// Stage 1 registers per-slice carry-select sums and group G/P; stage 2
// resolves the inter-slice carries, selects the sums and registers the
// result and flags. Backpressure ripples combinationally from out_ready.
module prefix_subtractor_32bit_pipe
  import prefix_sub_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  prefix_subtractor_32bit_pipe_if.slave  bus
);

  logic [WIDTH-1:0]    bp;
  slice_t [NSLICE-1:0] sum0_w;
  slice_t [NSLICE-1:0] sum1_w;
  logic   [NSLICE-1:0] g_w;
  logic   [NSLICE-1:0] p_w;

  s1_entry_t s1_next;
  s1_entry_t s1_reg;
  logic      s1_valid_reg;

  logic [NSLICE:0]  carry;
  logic [WIDTH-1:0] diff_next;
  logic             ovf_next;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic             s2_valid_reg;

  logic s1_load;
  logic s2_load;

  // A stage may take new content when it is empty or its content leaves.
  assign s2_load      = !s2_valid_reg || bus.out_ready;
  assign s1_load      = !s1_valid_reg || s2_load;
  assign bus.in_ready = s1_load;

  assign bp = ~bus.b;

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      prefix_slice_8bit_cs u_slice (
        .a     (bus.a[gi*SLICE +: SLICE]),
        .bp    (bp[gi*SLICE +: SLICE]),
        .sum0  (sum0_w[gi]),
        .sum1  (sum1_w[gi]),
        .g_grp (g_w[gi]),
        .p_grp (p_w[gi])
      );
    end
  endgenerate

  assign s1_next = '{
    sum0:  sum0_w,
    sum1:  sum1_w,
    g:     g_w,
    p:     p_w,
    a_msb: bus.a[WIDTH-1],
    b_msb: bus.b[WIDTH-1]
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_reg       <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_reg <= s1_next;
      end
    end
  end

  // Slice-level carry chain; the +1 of the two's complement is carry[0].
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_resolve
      assign carry[gi+1] = s1_reg.g[gi] | (s1_reg.p[gi] & carry[gi]);
      assign diff_next[gi*SLICE +: SLICE] = carry[gi] ? s1_reg.sum1[gi] : s1_reg.sum0[gi];
    end
  endgenerate

  // Overflow only possible when operand signs differ.
  assign ovf_next = (s1_reg.a_msb != s1_reg.b_msb) && (diff_next[WIDTH-1] != s1_reg.a_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      diff_reg     <= '0;
      borrow_reg   <= 1'b0;
      ovf_reg      <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        diff_reg   <= diff_next;
        borrow_reg <= ~carry[NSLICE];
        ovf_reg    <= ovf_next;
        zero_reg   <= (diff_next == '0);
      end
    end
  end

  assign bus.out_valid = s2_valid_reg;
  assign bus.diff      = diff_reg;
  assign bus.borrow    = borrow_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_prefix_subtractor_32bit_pipe.sv
// Self-checking bench for prefix_subtractor_32bit_pipe: directed vector
// table, backpressure and mid-operation reset sequences, then random
// traffic scored against an arithmetic reference model.
module tb_prefix_subtractor_32bit_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  int n_emit   = 0;

  vec_t        sb_q[$];
  logic [31:0] got_q[$];
  vec_t        vecs[11];

  prefix_subtractor_32bit_pipe_if bus ();

  prefix_subtractor_32bit_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain modular and signed arithmetic on the operands.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t   r;
    longint sd;
    r.a      = a;
    r.b      = b;
    r.diff   = a - b;
    r.borrow = (a < b);
    sd       = longint'($signed(a)) - longint'($signed(b));
    r.ovf    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    r.zero   = (r.diff == 32'd0);
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                              input logic br, input logic ov, input logic z);
    vec_t r;
    r.a = a; r.b = b; r.diff = d; r.borrow = br; r.ovf = ov; r.zero = z;
    return r;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Pops the oldest expected result and compares it with the DUT outputs.
  task automatic consume();
    vec_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL spurious_out: got diff 0x%08h, want no result", bus.diff);
      return;
    end
    e = sb_q.pop_front();
    n_emit++;
    got_q.push_back(bus.diff);
    check("sb_diff", bus.diff, e.diff);
    check("sb_borrow", 32'(bus.borrow), 32'(e.borrow));
    check("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
    check("sb_zero", 32'(bus.zero), 32'(e.zero));
    $display("txn out: a=0x%08h b=0x%08h diff=0x%08h borrow=%0d ovf=%0d zero=%0d",
             e.a, e.b, bus.diff, bus.borrow, bus.ovf, bus.zero);
  endtask

  // One cycle of stream traffic: drive after the falling edge, then decide
  // what the next rising edge accepts and emits.
  task automatic step(input logic v, input logic [31:0] ai, input logic [31:0] bi,
                      input logic ordy, output logic took);
    @(negedge clk);
    bus.in_valid  = v;
    bus.a         = ai;
    bus.b         = bi;
    bus.out_ready = ordy;
    #1;
    took = v && bus.in_ready;
    if (bus.out_valid && ordy) consume();
    if (took) sb_q.push_back(model(ai, bi));
  endtask

  // Single isolated operation on an empty pipe with out_ready held high.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    bus.out_ready = 1'b1;
    check("vec_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("vec_lat1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("vec_lat2_valid", 32'(bus.out_valid), 32'd1);
    check("vec_diff", bus.diff, v.diff);
    check("vec_borrow", 32'(bus.borrow), 32'(v.borrow));
    check("vec_ovf", 32'(bus.ovf), 32'(v.ovf));
    check("vec_zero", 32'(bus.zero), 32'(v.zero));
    $display("txn vec: a=0x%08h b=0x%08h diff=0x%08h borrow=%0d ovf=%0d zero=%0d",
             v.a, v.b, bus.diff, bus.borrow, bus.ovf, bus.zero);
  endtask

  initial begin
    logic took;
    logic hold;
    logic v;
    logic ordy;
    logic [31:0] pa;
    logic [31:0] pb;
    int idx;
    vec_t v7;

    vecs[0]  = mk(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    vecs[3]  = mk(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    vecs[5]  = mk(32'h0100_0000, 32'h0000_0001, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", bus.diff, 32'd0);
    check("rst_flags", {29'd0, bus.borrow, bus.ovf, bus.zero}, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 11; i++) apply_vec(vecs[i]);

    // Backpressure: 5 back-to-back ops, consumer stalled 4 cycles
    @(negedge clk);
    sb_q.delete();
    got_q.delete();
    n_emit = 0;
    idx = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step(1'b1, 32'(10 + idx), 32'd1, 1'b0, took);
      if (took) idx++;
      if (cyc >= 2) begin
        check("bp_stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
        check("bp_stall_diff", bus.diff, 32'd9);
      end
    end
    check("bp_accepted_stalled", 32'(idx), 32'd2);
    for (int c = 0; c < 40 && (idx < 5 || sb_q.size() > 0 || bus.out_valid); c++) begin
      step(idx < 5, 32'(10 + idx), 32'd1, 1'b1, took);
      if (took) idx++;
    end
    check("bp_accepted_total", 32'(idx), 32'd5);
    check("bp_emitted", 32'(n_emit), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check("bp_order", got_q[i], 32'(9 + i));

    // Reset with both stages full
    step(1'b1, 32'd20, 32'd1, 1'b0, took);
    step(1'b1, 32'd21, 32'd1, 1'b0, took);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_full_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_diff", bus.diff, 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    sb_q.delete();
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 32'd0, 32'd0, 1'b1, took);
      check("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end
    v7 = mk(32'd7, 32'd2, 32'd5, 1'b0, 1'b0, 1'b0);
    apply_vec(v7);

    // Random traffic with random backpressure
    @(negedge clk);
    sb_q.delete();
    hold = 1'b0;
    v    = 1'b0;
    pa   = '0;
    pb   = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold) begin
        v  = ($urandom_range(0, 3) != 0);
        pa = rnd_operand();
        pb = rnd_operand();
      end
      ordy = ($urandom_range(0, 3) != 0);
      step(v, pa, pb, ordy, took);
      hold = v && !took;
    end
    for (int c = 0; c < 20 && (sb_q.size() > 0 || bus.out_valid); c++) begin
      step(1'b0, 32'd0, 32'd0, 1'b1, took);
    end
    check("rand_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefix_subtractor_32bit_pipe.md
Name: prefix_subtractor_32bit_pipe

Overview:
- Pipelined 32-bit unsigned/signed subtractor computing diff = a - b as a + ~b + 1.
- Built from 8-bit prefix (Kogge-Stone) slices with carry-select, plus a registered inter-slice borrow resolution stage.
- Sits beside the 32-bit prefix adder in the datapath library as its inverse-operation counterpart.
- Adds a valid/ready stream interface, backpressure and status flags.

Parameters:
- WIDTH, 32, operand width; must equal SLICE*NSLICE.
- SLICE, 8, bits per prefix slice.
- NSLICE, 4, number of slices (derived: WIDTH/SLICE, not overridden separately).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block accepts the pair this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow  output  1  1 iff unsigned a < b (inverted final carry).
- ovf  output  1  signed overflow: a[31] != b[31] and diff[31] != a[31].
- zero  output  1  diff == 0.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, all data registers 0; out_valid=0, diff=0, borrow=0, ovf=0, zero=0; in_ready=1 once the stage logic settles.
- Stage 1 (capture on in_valid && in_ready), per slice k:
  - Compute bp = ~b.
  - Run 8-bit prefix P/G over a and bp.
  - Register sum0_k (slice carry-in 0), sum1_k (slice carry-in 1), group G_k and group P_k.
  - Also register a[31] and b[31] for ovf.
- Stage 2:
  - Resolve slice carries with a 4-input prefix: c0=1 (subtraction carry-in), c(k+1)=G_k | (P_k & c_k).
  - Select per slice: diff slice k = c_k ? sum1_k : sum0_k.
  - borrow = ~c4; ovf and zero as defined under Ports.
  - All outputs are registered.
- Latency: exactly 2 clk edges from acceptance to out_valid=1 when out_ready is held 1. Throughput: 1 result per cycle.
- Handshake:
  - s2_load = !s2_valid | out_ready.
  - s1_load = !s1_valid | s2_load.
  - in_ready = s1_load. This is a combinational out_ready -> in_ready path, permitted.
  - Outputs hold stable while out_valid=1 && out_ready=0.
  - A result is consumed on out_valid && out_ready.
  - A stage with valid=0 advances a bubble.
- Simultaneous events:
  - Accept and emit in the same cycle are allowed; order is strictly FIFO.
  - When full and stalled (both stages valid, out_ready=0): in_ready=0; an in_valid pulse is not taken and the source must hold its data.
  - in_valid while in_ready=0: ignored.
  - a, b may change freely when in_valid=0.
- Wrap-around: modulo 2^32. No saturation.
- Reset mid-operation: both valids clear immediately and asynchronously; in-flight results are discarded; nothing reappears after release.

Decomposition:
- Package prefix_sub_pkg holds:
  - constants WIDTH=32, SLICE=8, NSLICE=4;
  - typedef slice_t (logic [SLICE-1:0]);
  - typedef s1_entry_t, a packed struct of sum0[NSLICE], sum1[NSLICE], G[NSLICE], P[NSLICE], a_msb, b_msb.
- Sub-module prefix_slice_8bit_cs:
  - Combinational 8-bit Kogge-Stone slice.
  - Outputs sum0, sum1, group G and group P.
  - Instantiated NSLICE times in a generate loop.

Test Plan:
- Reset, then a=5, b=3 with out_ready=1 -> 2 cycles later diff=0x00000002, borrow=0, ovf=0, zero=0.
- a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow=1, ovf=0. Then a=b=0x12345678 -> diff=0, zero=1, borrow=0.
- a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1, borrow=0. Then a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, borrow=1.
- Cross-slice borrow: a=0x01000000, b=0x00000001 -> diff=0x00FFFFFF; a=0x00000100, b=0x00000001 -> diff=0x000000FF.
- Backpressure: issue 5 back-to-back ops (a=10..14, b=1) with out_ready=0 for 4 cycles:
  - exactly 2 accepted, then in_ready=0;
  - diff=9 held stable throughout the stall;
  - after out_ready=1, results 9..13 appear in order with none lost or duplicated.
- Reset mid-operation: both stages valid, pulse rst_n=0 between clock edges -> out_valid=0 immediately, diff=0; no stale result after release; the next op a=7, b=2 yields diff=5 at latency 2.
